// File: rtl/frame_composer_pkg.sv
// Shared types, screen constants and the frame-buffer address packing for frame_composer.
// The optional feature macro FRAME_COMPOSER_SUBPIXEL_Y_EN widens the per-object vertical
// position from a 3-bit page to a 6-bit pixel row.
package frame_composer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StObj,
    StRd,
    StWr,
    StSwap
  } state_e;

  localparam int unsigned SCR_COLS  = 128;
  localparam int unsigned SCR_PAGES = 8;
  localparam int unsigned BUF_AW    = 10;

`ifdef FRAME_COMPOSER_SUBPIXEL_Y_EN
  localparam int unsigned POS_W = 6;
`else
  localparam int unsigned POS_W = 3;
`endif

  // Driver layout: {page-select bit (col[6]), page[2:0], col[5:0]}.
  function automatic logic [BUF_AW-1:0] buf_addr(input logic [6:0] col, input logic [2:0] page);
    return {col[6], page, col[5:0]};
  endfunction

endpackage

// File: rtl/frame_composer_if.sv
// Bundle of every non-clock/reset signal of frame_composer.
//   slave  : composer side (object list, sprite ROM port, driver read port, status strobes).
//   master : environment side (drives ticks, objects, ROM data and read addresses).
// With FRAME_COMPOSER_SUBPIXEL_Y_EN defined, obj_page_i is replaced by obj_y_i (pixel row).
interface frame_composer_if #(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned SPR_W   = 16,
  parameter int unsigned SPR_PG  = 2
) ();
  localparam int unsigned SPR_AW = ID_W + $clog2(SPR_PG) + $clog2(SPR_W);

  logic                      frame_tick_i;
  logic [NUM_OBJ-1:0]        obj_valid_i;
  logic [NUM_OBJ*7-1:0]      obj_x_i;
`ifdef FRAME_COMPOSER_SUBPIXEL_Y_EN
  logic [NUM_OBJ*6-1:0]      obj_y_i;
`else
  logic [NUM_OBJ*3-1:0]      obj_page_i;
`endif
  logic [NUM_OBJ*ID_W-1:0]   obj_id_i;
  logic [SPR_AW-1:0]         spr_addr_o;
  logic [7:0]                spr_data_i;
  logic [9:0]                rd_addr_i;
  logic [7:0]                rd_data_o;
  logic                      start_o;
  logic                      busy_o;
  logic                      drop_o;

  modport slave (
    input  frame_tick_i, obj_valid_i, obj_x_i,
`ifdef FRAME_COMPOSER_SUBPIXEL_Y_EN
    input  obj_y_i,
`else
    input  obj_page_i,
`endif
    input  obj_id_i, spr_data_i, rd_addr_i,
    output spr_addr_o, rd_data_o, start_o, busy_o, drop_o
  );

  modport master (
    output frame_tick_i, obj_valid_i, obj_x_i,
`ifdef FRAME_COMPOSER_SUBPIXEL_Y_EN
    output obj_y_i,
`else
    output obj_page_i,
`endif
    output obj_id_i, spr_data_i, rd_addr_i,
    input  spr_addr_o, rd_data_o, start_o, busy_o, drop_o
  );

endinterface

// File: rtl/fc_bank_ram.sv
// One 1024x8 frame-buffer bank: a single write port and a registered read port.
//   clk, rst       : clock; rst only clears the read data register (contents are not reset).
//   we/waddr/wdata : write port.
//   raddr/rdata    : read port, data valid one cycle after raddr.
module fc_bank_ram
  import frame_composer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**BUF_AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_composer.sv
// Frame composer: on each frame tick clears the back bank, ORs up to NUM_OBJ sprites into it
// by read-modify-write, swaps banks and strobes start_o for the LCD driver.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : frame_composer_if.slave (object list, sprite ROM, driver read port, status).
// Optional: FRAME_COMPOSER_SUBPIXEL_Y_EN enables pixel-row placement (two shifted writes/byte).
module frame_composer
  import frame_composer_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned SPR_W   = 16,
  parameter int unsigned SPR_PG  = 2
) (
  input logic             clk,
  input logic             rst,
  frame_composer_if.slave bus
);
  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned PW = $clog2(SPR_PG);
  localparam int unsigned KW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int unsigned SW = $clog2(NUM_OBJ + 1);

  state_e            state_q, state_d;
  logic              front_q, front_sel_q, start_q, drop_q;
  logic [BUF_AW-1:0] clr_q, clr_d;
  logic [SW-1:0]     slot_q, slot_d;   // first slot not yet scanned
  logic [KW-1:0]     cur_q, cur_d;     // slot being blitted
  logic [CW-1:0]     col_q, col_d;
  logic [PW-1:0]     pg_q, pg_d;
  logic              half_q, half_d;   // second (lower-page) write of a shifted byte

  logic [NUM_OBJ-1:0] valid_q;
  logic [6:0]         x_q   [NUM_OBJ];
  logic [POS_W-1:0]   pos_q [NUM_OBJ];
  logic [ID_W-1:0]    id_q  [NUM_OBJ];
  logic [NUM_OBJ*POS_W-1:0] pos_in;
  logic               snap;

`ifdef FRAME_COMPOSER_SUBPIXEL_Y_EN
  assign pos_in = bus.obj_y_i;
`else
  assign pos_in = bus.obj_page_i;
`endif

  // Object snapshot taken on the accepted tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        x_q[k]   <= '0;
        pos_q[k] <= '0;
        id_q[k]  <= '0;
      end
    end else if (snap) begin
      valid_q <= bus.obj_valid_i;
      for (int k = 0; k < NUM_OBJ; k++) begin
        x_q[k]   <= bus.obj_x_i[k*7 +: 7];
        pos_q[k] <= pos_in[k*POS_W +: POS_W];
        id_q[k]  <= bus.obj_id_i[k*ID_W +: ID_W];
      end
    end
  end

  // Target location of the current byte.
  logic [6:0]        cur_x;
  logic [POS_W-1:0]  cur_pos;
  logic [2:0]        base_pg;
  logic [7:0]        tc;
  logic [3:0]        tp;
  logic              clip, more_half, byte_last;
  logic [BUF_AW-1:0] tgt_addr;
  logic [7:0]        spr_byte, back_rdata, rdata0, rdata1;

  assign cur_x   = x_q[cur_q];
  assign cur_pos = pos_q[cur_q];

`ifdef FRAME_COMPOSER_SUBPIXEL_Y_EN
  logic [2:0] r;
  assign r         = cur_pos[2:0];
  assign base_pg   = cur_pos[5:3];
  assign more_half = !half_q && (r != 3'd0);
  assign spr_byte  = half_q ? (bus.spr_data_i >> (4'd8 - 4'(r))) : (bus.spr_data_i << r);
`else
  assign base_pg   = cur_pos;
  assign more_half = 1'b0;
  assign spr_byte  = bus.spr_data_i;
`endif

  assign tc        = {1'b0, cur_x} + 8'(col_q);
  assign tp        = 4'(base_pg) + 4'(pg_q) + 4'(half_q);
  assign clip      = (tc >= 8'(SCR_COLS)) || (tp >= 4'(SCR_PAGES));
  assign tgt_addr  = buf_addr(tc[6:0], tp[2:0]);
  assign byte_last = (col_q == '1) && (pg_q == '1);

  // Position after finishing the current write (or skip); columns advance fastest.
  logic [CW-1:0] step_col;
  logic [PW-1:0] step_pg;
  logic          step_half;
  state_e        step_state;

  always_comb begin
    step_col   = col_q;
    step_pg    = pg_q;
    step_half  = 1'b1;
    step_state = StRd;
    if (!more_half) begin
      step_half  = 1'b0;
      step_col   = col_q + CW'(1);
      step_pg    = (col_q == '1) ? pg_q + PW'(1) : pg_q;
      step_state = byte_last ? StObj : StRd;
    end
  end

  logic              we, found;
  logic [BUF_AW-1:0] waddr;
  logic [7:0]        wdata;
  logic [KW-1:0]     found_k;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    slot_d  = slot_q;
    cur_d   = cur_q;
    col_d   = col_q;
    pg_d    = pg_q;
    half_d  = half_q;
    snap    = 1'b0;
    we      = 1'b0;
    waddr   = tgt_addr;
    wdata   = back_rdata | spr_byte;
    found   = 1'b0;
    found_k = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick_i) begin
          snap    = 1'b1;
          clr_d   = '0;
          slot_d  = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        we    = 1'b1;
        waddr = clr_q;
        wdata = '0;
        clr_d = clr_q + 10'd1;
        if (clr_q == '1) state_d = StObj;
      end
      StObj: begin
        // Descending scan so the lowest eligible slot wins.
        for (int k = NUM_OBJ - 1; k >= 0; k--) begin
          if (SW'(k) >= slot_q && valid_q[k]) begin
            found   = 1'b1;
            found_k = KW'(k);
          end
        end
        if (found) begin
          cur_d   = found_k;
          slot_d  = SW'(found_k) + SW'(1);
          col_d   = '0;
          pg_d    = '0;
          half_d  = 1'b0;
          state_d = StRd;
        end else begin
          state_d = StSwap;
        end
      end
      StRd: begin
        if (clip) begin
          col_d   = step_col;
          pg_d    = step_pg;
          half_d  = step_half;
          state_d = step_state;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        we      = 1'b1;
        col_d   = step_col;
        pg_d    = step_pg;
        half_d  = step_half;
        state_d = step_state;
      end
      StSwap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      front_q     <= 1'b0;
      front_sel_q <= 1'b0;
      start_q     <= 1'b0;
      drop_q      <= 1'b0;
      clr_q       <= '0;
      slot_q      <= '0;
      cur_q       <= '0;
      col_q       <= '0;
      pg_q        <= '0;
      half_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_q;
      if (state_q == StSwap) front_q <= ~front_q;
      // Registered so start_o coincides with the new front bank being readable.
      start_q     <= (state_q == StSwap);
      drop_q      <= bus.frame_tick_i && (state_q != StIdle);
      clr_q       <= clr_d;
      slot_q      <= slot_d;
      cur_q       <= cur_d;
      col_q       <= col_d;
      pg_q        <= pg_d;
      half_q      <= half_d;
    end
  end

  // Bank front_q serves the driver; the other bank takes all composition traffic.
  logic              we0, we1;
  logic [BUF_AW-1:0] raddr0, raddr1;

  assign we0        = we & front_q;
  assign we1        = we & ~front_q;
  assign raddr0     = front_q ? tgt_addr : bus.rd_addr_i;
  assign raddr1     = front_q ? bus.rd_addr_i : tgt_addr;
  assign back_rdata = front_q ? rdata0 : rdata1;

  fc_bank_ram u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we0),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr0),
    .rdata (rdata0)
  );

  fc_bank_ram u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we1),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr1),
    .rdata (rdata1)
  );

  assign bus.rd_data_o  = front_sel_q ? rdata1 : rdata0;
  assign bus.spr_addr_o = {id_q[cur_q], pg_q, col_q};
  assign bus.start_o    = start_q;
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.drop_o     = drop_q;

endmodule
